stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
// - N-channel, WIDTH-bit stream multiplexer. Successor to the combinational 2:1/4:1 mux tree.
// - Picks one input channel per cycle and drives it into a one-entry output register.
//   Pick is either a fixed select or round-robin arbitration.
// - All inputs and the output use valid/ready handshakes.
// - Used where several producers share one consumer, e.g. display or UART paths.
// PARAMETERS
// - WIDTH  8             data bits per channel
// - N      4             number of input channels, >= 2
// - SELW   $clog2(N)     width of sel and grant (derived, do not override)
// PORTS
// - clk        in   1        single clock, rising edge
// - reset      in   1        asynchronous, active-high
// - in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
// - in_valid   in   N        per-channel valid
// - in_ready   out  N        per-channel ready, combinational, at most one bit high
// - mode       in   1        0 = fixed select via sel; 1 = round-robin
// - sel        in   SELW     channel index used when mode = 0
// - out_data   out  WIDTH    registered output data
// - out_valid  out  1        registered output valid
// - out_ready  in   1        downstream ready
// - grant      out  SELW     registered index of the channel held in out_data
// BEHAVIOUR
// - Reset (async, active-high):
//   - out_valid = 0, out_data = 0, grant = 0.
//   - Round-robin pointer rr_last = N-1, so channel 0 has first priority.
// - can_load = !out_valid | out_ready.
// - Candidate channel c:
//   - mode = 0: c = sel, and only if sel < N and in_valid[sel]. Otherwise no candidate.
//   - mode = 1: c is the first i with in_valid[i] set, searching from rr_last+1 upward,
//     wrapping from N-1 to 0. No candidate if in_valid == 0.
// - Ready: in_ready[c] = can_load when a candidate exists. All other in_ready bits = 0.
// - Transfer on channel c (in_valid[c] & in_ready[c]). At the next edge:
//   - out_data <= slice c, out_valid <= 1, grant <= c.
//   - In mode 1 only: rr_last <= c.
// - No transfer and out_ready = 1: out_valid <= 0. out_data and grant hold their values.
// - Output hold: while out_valid & !out_ready, out_data and grant are stable.
// - Simultaneous drain and load: back-to-back throughput of one word per cycle, no bubble.
// - Latency: exactly 1 cycle from input transfer to out_valid.
// - Fairness (mode 1): with all channels valid and out_ready = 1, grants go 0,1,...,N-1,0,...
// - Mode or sel changes take effect in the same cycle's candidate selection. A word already
//   held in the output register is not affected.
// - rr_last is not updated in mode 0.
// - sel >= N (possible when N is not a power of 2): nothing is selected, all in_ready = 0.
// - Reset asserted mid-transfer: the held word is discarded and out_valid drops immediately.
// - No combinational path from in_valid to out_valid. out_ready -> in_ready is combinational.
// TESTING
// - Reset: drive reset = 1 with stimulus active -> out_valid = 0, out_data = 0, grant = 0,
//   in_ready = 0 while no candidate.
// - Fixed select: mode = 0, sel = 2, in_valid = 4'b1111, ch2 = 8'hA5, out_ready = 1
//   -> next cycle out_data = 8'hA5, grant = 2. in_ready = 4'b0100 every cycle.
// - Round-robin: mode = 1, in_valid = 4'b1111, out_ready = 1 for 8 cycles
//   -> grant sequence 0,1,2,3,0,1,2,3. Then in_valid = 4'b1010 -> grants alternate 1,3.
// - Backpressure: out_ready = 0 after the first load of 8'h3C
//   -> out_data stays 8'h3C, in_ready = 0 for 5 cycles. Raising out_ready loads the next
//   word in the same cycle, with no bubble.
// - Wrap and empty: mode = 1, rr_last = 3, only in_valid[0] set -> grant 0.
//   in_valid = 0 -> out_valid falls after a drain.
// - Mid-operation reset: assert reset while out_valid = 1 and out_ready = 0
//   -> out_valid = 0 immediately. After release, round-robin restarts at channel 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed-select or round-robin
// pick, feeding a one-entry output register. Includes a protocol checker.

module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    grant
);

  logic [SELW-1:0]  rr_last;
  logic [SELW:0]    pick;
  logic             can_load;
  logic             cand_found;
  logic [SELW-1:0]  cand;
  logic [WIDTH-1:0] cand_data;
  logic             xfer;

  function automatic logic bit_at(input logic [N-1:0] v, input int idx);
    return |(v & (N'(1) << idx));
  endfunction

  // Result packs {found, index}; sel beyond N-1 never selects anything.
  function automatic logic [SELW:0] fixed_pick(input logic [N-1:0] valid,
                                               input logic [SELW-1:0] s);
    logic [SELW:0] r;
    if ((int'(s) < N) && bit_at(valid, int'(s))) begin
      r = {1'b1, s};
    end else begin
      r = {1'b0, s};
    end
    return r;
  endfunction

  function automatic logic [SELW:0] rr_pick(input logic [N-1:0] valid,
                                            input logic [SELW-1:0] last);
    logic [SELW:0] r;
    int            idx;
    r = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!r[SELW] && bit_at(valid, idx)) begin
        r = {1'b1, SELW'(idx)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Candidate selection, per-channel ready and transfer decision.
  always_comb begin
    can_load = !out_valid || out_ready;
    if (mode) begin
      pick = rr_pick(in_valid, rr_last);
    end else begin
      pick = fixed_pick(in_valid, sel);
    end
    cand_found = pick[SELW];
    cand       = pick[SELW-1:0];
    cand_data  = WIDTH'(in_data >> (int'(cand) * WIDTH));
    xfer       = cand_found && can_load;
    if (xfer) begin
      in_ready = N'(1) << cand;
    end else begin
      in_ready = '0;
    end
  end

  // Output register and round-robin pointer; load wins over drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant     <= '0;
      rr_last   <= SELW'(N - 1);
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= cand_data;
        grant     <= cand;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
      if (xfer && mode) begin
        rr_last <= cand;
      end
    end
  end

endmodule

module stream_mux_rr_checker #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input logic             clk,
  input logic             reset,
  input logic [N-1:0]     in_valid,
  input logic [N-1:0]     in_ready,
  input logic [WIDTH-1:0] out_data,
  input logic             out_valid,
  input logic             out_ready,
  input logic [SELW-1:0]  grant
);

  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(in_ready));

  a_ready_needs_valid: assert property (@(posedge clk) disable iff (reset)
    (in_ready & ~in_valid) == '0);

  // A stalled output word must not move or vanish.
  a_hold: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(grant)));

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized and directed bench for stream_mux_rr against a queue-free
// behavioural model of the pick/hold rules.

module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  grant3;

  int checks = 0;
  int errors = 0;

  int         m_rr;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_grant;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(8), .N(4)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .grant(grant)
  );

  stream_mux_rr_checker #(.WIDTH(8), .N(4)) u_chk (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .grant(grant)
  );

  stream_mux_rr #(.WIDTH(8), .N(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(1'b0), .sel(sel3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(1'b1), .grant(grant3)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rr    = 3;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_grant = 0;
  endtask

  // Fixed mode: sel if valid. Round-robin: lowest valid index above the last
  // winner, otherwise the lowest valid index overall.
  function automatic int model_pick();
    int best;
    best = -1;
    if (mode == 1'b0) begin
      if (int'(sel) < 4 && in_valid[sel]) best = int'(sel);
    end else begin
      for (int i = 0; i < 4; i++)
        if (best < 0 && in_valid[i] && i > m_rr) best = i;
      for (int i = 0; i < 4; i++)
        if (best < 0 && in_valid[i]) best = i;
    end
    return best;
  endfunction

  task automatic cycle(input string tag);
    int         c;
    bit         take;
    logic [3:0] er;
    #1;
    c    = model_pick();
    take = (c >= 0) && (!m_valid || out_ready);
    er   = take ? 4'(1 << c) : 4'b0000;
    check_val({tag, "_rdy"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    if (take) begin
      m_valid = 1'b1;
      m_data  = in_data[c*8 +: 8];
      m_grant = c;
      if (mode) m_rr = c;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check_val({tag, "_vld"}, 32'(out_valid), 32'(m_valid));
    check_val({tag, "_dat"}, 32'(out_data), 32'(m_data));
    check_val({tag, "_gnt"}, 32'(grant), 32'(m_grant));
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = $urandom;
    in_valid  = 4'b0000;
    mode      = 1'b1;
    sel       = 2'd2;
    out_ready = 1'b1;
    in_data3  = 24'h332211;
    in_valid3 = 3'b111;
    sel3      = 2'd3;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_vld", 32'(out_valid), 32'd0);
    check_val("rst_dat", 32'(out_data), 32'd0);
    check_val("rst_gnt", 32'(grant), 32'd0);
    check_val("rst_rdy", 32'(in_ready), 32'd0);
    reset = 1'b0;

    // Three-channel instance: sel = 3 selects nothing.
    repeat (2) @(posedge clk);
    #1;
    check_val("n3_sel3_rdy", 32'(in_ready3), 32'd0);
    check_val("n3_sel3_vld", 32'(out_valid3), 32'd0);
    sel3 = 2'd2;
    #1;
    check_val("n3_sel2_rdy", 32'(in_ready3), 32'(3'b100));
    @(posedge clk);
    #1;
    check_val("n3_sel2_dat", 32'(out_data3), 32'h33);
    check_val("n3_sel2_gnt", 32'(grant3), 32'd2);

    // Fixed select of channel 2.
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      in_data = $urandom;
      in_data[23:16] = 8'hA5;
      cycle("fix");
      check_val("fix_dat", 32'(out_data), 32'hA5);
      check_val("fix_gnt", 32'(grant), 32'd2);
      check_val("fix_rdy", 32'(in_ready), 32'(4'b0100));
    end

    // Round-robin fairness, then sparse valids.
    mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = $urandom;
      cycle("rr");
      check_val("rr_seq", 32'(grant), 32'(k % 4));
    end
    in_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      in_data = $urandom;
      cycle("rr2");
      check_val("rr2_seq", 32'(grant), (k % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Wrap from channel 3 to 0, then backpressure.
    in_valid = 4'b0001;
    in_data  = 32'h000000_3C;
    cycle("wrap");
    check_val("wrap_gnt", 32'(grant), 32'd0);
    out_ready = 1'b0;
    in_data   = 32'h000000_11;
    for (int k = 0; k < 5; k++) begin
      cycle("bp");
      check_val("bp_dat", 32'(out_data), 32'h3C);
      check_val("bp_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_release_rdy", 32'(in_ready), 32'(4'b0001));
    cycle("bp_rel");
    check_val("bp_rel_dat", 32'(out_data), 32'h11);
    check_val("bp_rel_vld", 32'(out_valid), 32'd1);
    in_valid = 4'b0000;
    cycle("empty");
    check_val("empty_vld", 32'(out_valid), 32'd0);

    // Random traffic in both modes.
    for (int k = 0; k < 400; k++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom_range(0, 15));
      mode      = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 2) != 0);
      cycle("rand");
    end

    // Reset while a word is stalled in the output register.
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = $urandom;
    cycle("pre_rst");
    out_ready = 1'b0;
    cycle("pre_rst_hold");
    check_val("pre_rst_vld", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check_val("mid_rst_vld", 32'(out_valid), 32'd0);
    check_val("mid_rst_dat", 32'(out_data), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    in_data   = $urandom;
    cycle("post_rst");
    check_val("post_rst_gnt", 32'(grant), 32'd0);
    cycle("post_rst2");
    check_val("post_rst2_gnt", 32'(grant), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
